// File: rtl/lfsr_rand_sched.sv
// lfsr_rand_sched
//   Sequences the external 20-bit LFSR (x^20+x^13+x^9+x^5+1) that feeds
//   randomness to the AES core. It loads a seed, runs a fixed warm-up, and
//   then hands successive LFSR words to N requesters in round-robin order.
//   Each word is used once. After MAX_USES grants the block asks for a reseed.
//
// Ports
//   clk, rst     clock (rising edge), synchronous active-high reset
//   seed_valid   one-cycle strobe qualifying seed_data
//   seed_data    seed source; only [19:0] is used
//   lfsr_load    load lfsr_seed into the LFSR at the next edge
//   lfsr_seed    seed for the LFSR (never zero while lfsr_load is high)
//   lfsr_step    advance the LFSR one state at the next edge
//   lfsr_value   current LFSR state
//   req          per-requester request, held until granted
//   gnt          one-hot grant, combinational from req/state/rr_ptr
//   rnd_out      lfsr_value during a grant cycle, otherwise 0
//   ready        high in SERVE
//   reseed_req   high while unseeded or exhausted
module lfsr_rand_sched #(
    parameter int N        = 4,
    parameter int WARM     = 16,
    parameter int MAX_USES = 1024
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           seed_valid,
    input  logic [127:0]   seed_data,
    output logic           lfsr_load,
    output logic [19:0]    lfsr_seed,
    output logic           lfsr_step,
    input  logic [19:0]    lfsr_value,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [19:0]    rnd_out,
    output logic           ready,
    output logic           reseed_req
);

    localparam int PW  = $clog2(N);
    localparam int PW1 = PW + 1;

    typedef enum logic [2:0] {
        UNSEEDED,
        LOAD,
        WARMUP,
        SERVE,
        EXHAUST
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   rr_ptr_q;
    logic [7:0]      warm_cnt_q;
    logic [15:0]     use_cnt_q;
    logic [19:0]     seed_q;

    logic            found;
    logic            grant;
    logic [PW-1:0]   win;
    logic [PW1-1:0]  idx;
    logic [PW-1:0]   rr_next;

    // Only the low 20 bits of the seed bus feed the LFSR.
    logic unused_seed_bits;
    assign unused_seed_bits = ^seed_data[127:20];

    // Round-robin search: first set request at or above rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, rr_ptr_q} + PW1'(i);
            if (idx >= PW1'(N))
                idx = idx - PW1'(N);
            if (!found && req[idx[PW-1:0]]) begin
                found = 1'b1;
                win   = idx[PW-1:0];
            end
        end
    end

    assign grant   = (state_q == SERVE) && found;
    assign gnt     = grant ? ({{(N-1){1'b0}}, 1'b1} << win) : '0;
    assign rnd_out = grant ? lfsr_value : '0;
    assign rr_next = (win == PW'(N - 1)) ? '0 : win + 1'b1;
    assign lfsr_seed = seed_q;

    always_comb begin
        state_d    = state_q;
        lfsr_load  = 1'b0;
        lfsr_step  = 1'b0;
        ready      = 1'b0;
        reseed_req = 1'b0;
        case (state_q)
            UNSEEDED, EXHAUST: reseed_req = 1'b1;
            LOAD: begin
                lfsr_load = 1'b1;
                state_d   = WARMUP;
            end
            WARMUP: begin
                lfsr_step = 1'b1;
                if (warm_cnt_q == 8'(WARM - 1))
                    state_d = SERVE;
            end
            SERVE: begin
                ready = 1'b1;
                if (grant) begin
                    lfsr_step = 1'b1;
                    if (use_cnt_q == 16'(MAX_USES - 1))
                        state_d = EXHAUST;
                end
            end
            default: state_d = UNSEEDED;
        endcase
        // A new seed always restarts the sequence, whatever was in flight.
        if (seed_valid)
            state_d = LOAD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= UNSEEDED;
            rr_ptr_q   <= '0;
            warm_cnt_q <= '0;
            use_cnt_q  <= '0;
            seed_q     <= '0;
        end else begin
            state_q <= state_d;
            // Zero is the LFSR lock-up state, so substitute 1.
            if (seed_valid)
                seed_q <= (seed_data[19:0] == 20'h0) ? 20'h00001 : seed_data[19:0];
            if (grant) begin
                rr_ptr_q  <= rr_next;
                use_cnt_q <= use_cnt_q + 16'd1;
            end
            case (state_q)
                LOAD: warm_cnt_q <= '0;
                WARMUP: begin
                    warm_cnt_q <= warm_cnt_q + 8'd1;
                    if (warm_cnt_q == 8'(WARM - 1))
                        use_cnt_q <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
